// File: rtl/ppb_pkg.sv
`default_nettype none
// ============================================================================
// ppb_pkg : shared constants and state type for the PMOD probe bus host
// Rev 1.0
// ============================================================================
package ppb_pkg;

  localparam int PPB_HEADER_BEATS = 8;
  localparam int PPB_BLOCK_W      = 3;
  localparam int PPB_ID_W         = 23;
  // Header carries {1'b0, id}, one block per header beat
  localparam int PPB_ID_WORD_W    = PPB_HEADER_BEATS * PPB_BLOCK_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    FINISH = 2'd3
  } ppb_state_t;

  function automatic int ppb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppb_bus_clkgen.sv
`default_nettype none
// ============================================================================
// ppb_bus_clkgen : beat phase counter and bus clock register for ppb_host
// Rev 1.0
// ============================================================================
module ppb_bus_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_bus_clk,
  output logic o_beat_start,
  output logic o_sample
);

  localparam int PH_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PH_W-1:0] c_HALF_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] c_BEAT_LAST = PH_W'(2 * CLK_DIV - 1);

  logic [PH_W-1:0] r_phase;
  logic            r_bus_clk;

  // Strobes mark the edge that ends the low half and the edge that ends the beat
  assign o_sample     = i_en && (r_phase == c_HALF_LAST);
  assign o_beat_start = i_en && (r_phase == c_BEAT_LAST);
  assign o_bus_clk    = r_bus_clk;

  always_ff @(posedge clk) begin
    if (!rst || !i_en) begin
      r_phase   <= '0;
      r_bus_clk <= 1'b0;
    end else if (o_beat_start) begin
      r_phase   <= '0;
      r_bus_clk <= 1'b0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
      if (o_sample) begin
        r_bus_clk <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ppb_host.sv
`default_nettype none
// ============================================================================
// ppb_host : PMOD probe bus host-side initiator (header + data frame engine)
// Rev 1.0
// ============================================================================
module ppb_host
  import ppb_pkg::*;
#(
  parameter int                   INPUT_BLOCKS  = 20,
  parameter int                   OUTPUT_BLOCKS = 40,
  parameter int                   CLK_DIV       = 2,
  parameter logic [PPB_ID_W-1:0]  PROJECT_ID    = 23'h31c748
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                id_ok,
  input  logic [PPB_BLOCK_W*INPUT_BLOCKS-1:0] host_inputs,
  output logic [PPB_BLOCK_W*OUTPUT_BLOCKS-1:0] host_outputs,
  output logic                                pmod_bus_clk,
  output logic                                pmod_bus_control,
  output logic [PPB_BLOCK_W-1:0]              pmod_bus_poti,
  input  logic [PPB_BLOCK_W-1:0]              pmod_bus_pito
);

  localparam int N      = ppb_max(INPUT_BLOCKS, OUTPUT_BLOCKS);
  localparam int BEAT_W = $clog2(ppb_max(N, PPB_HEADER_BEATS)) + 1;
  localparam int IN_W   = PPB_BLOCK_W * INPUT_BLOCKS;
  localparam int OUT_W  = PPB_BLOCK_W * OUTPUT_BLOCKS;
  localparam int HDR_W  = PPB_ID_WORD_W;
  localparam int TX_W   = IN_W + HDR_W - PPB_BLOCK_W;
  localparam int RX_W   = HDR_W + OUT_W;

  localparam logic [HDR_W-1:0]  c_ID_WORD   = {1'b0, PROJECT_ID};
  localparam logic [BEAT_W-1:0] c_HDR_LAST  = BEAT_W'(PPB_HEADER_BEATS - 1);
  localparam logic [BEAT_W-1:0] c_DATA_LAST = BEAT_W'(N - 1);
  localparam logic [BEAT_W-1:0] c_OUT_BLKS  = BEAT_W'(OUTPUT_BLOCKS);

  ppb_state_t        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [TX_W-1:0]   r_tx;
  logic [RX_W-1:0]   r_rx;
  logic              r_busy;
  logic              r_done;
  logic              r_id_ok;
  logic [OUT_W-1:0]  r_outputs;
  logic              r_control;
  logic [PPB_BLOCK_W-1:0] r_poti;

  logic w_bus_clk;
  logic w_beat_start;
  logic w_sample;
  logic w_id_match;

  ppb_bus_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_busy),
    .o_bus_clk    (w_bus_clk),
    .o_beat_start (w_beat_start),
    .o_sample     (w_sample)
  );

  // Received blocks enter at the top, so after the frame block 0 sits at bit 0
  assign w_id_match = (r_rx[PPB_ID_W-1:0] == PROJECT_ID);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_id_ok   <= 1'b0;
      r_outputs <= '0;
      r_control <= 1'b0;
      r_poti    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Beat 0 starts on this edge; the rest of the frame drains r_tx
            r_state   <= HEADER;
            r_busy    <= 1'b1;
            r_control <= 1'b1;
            r_poti    <= c_ID_WORD[PPB_BLOCK_W-1:0];
            r_tx      <= {host_inputs, c_ID_WORD[HDR_W-1:PPB_BLOCK_W]};
            r_beat    <= '0;
          end
        end

        HEADER: begin
          if (w_sample) begin
            r_rx <= {pmod_bus_pito, r_rx[RX_W-1:PPB_BLOCK_W]};
          end
          if (w_beat_start) begin
            r_poti <= r_tx[PPB_BLOCK_W-1:0];
            r_tx   <= r_tx >> PPB_BLOCK_W;
            if (r_beat == c_HDR_LAST) begin
              r_state   <= DATA;
              r_control <= 1'b0;
              r_beat    <= '0;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end

        DATA: begin
          if (w_sample && (r_beat < c_OUT_BLKS)) begin
            r_rx <= {pmod_bus_pito, r_rx[RX_W-1:PPB_BLOCK_W]};
          end
          if (w_beat_start) begin
            if (r_beat == c_DATA_LAST) begin
              r_state <= FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_poti  <= '0;
            end else begin
              // Zeros shifted in behind the last input block pad the tail beats
              r_poti <= r_tx[PPB_BLOCK_W-1:0];
              r_tx   <= r_tx >> PPB_BLOCK_W;
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end

        FINISH: begin
          r_id_ok <= w_id_match;
          if (w_id_match) begin
            r_outputs <= r_rx[RX_W-1:HDR_W];
          end
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign id_ok            = r_id_ok;
  assign host_outputs     = r_outputs;
  assign pmod_bus_clk     = w_bus_clk;
  assign pmod_bus_control = r_control;
  assign pmod_bus_poti    = r_poti;

endmodule
`default_nettype wire

// File: tb/tb_ppb_host.sv
`default_nettype none
// ============================================================================
// tb_ppb_host : randomized bench for ppb_host with a timing-level frame model
// Rev 1.0
// ============================================================================
module tb_ppb_host;

  localparam int IB = 20;
  localparam int OB = 40;
  localparam int N  = 40;
  localparam int HB = 8;
  localparam logic [22:0] PID = 23'h31c748;
  localparam logic [23:0] IDW = {1'b0, PID};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start [2];
  logic [3*IB-1:0] hin   [2];
  logic            busy  [2];
  logic            done  [2];
  logic            idok  [2];
  logic [3*OB-1:0] hout  [2];
  logic            bclk  [2];
  logic            ctrl  [2];
  logic [2:0]      poti  [2];
  logic [2:0]      pito  [2];

  ppb_host #(.INPUT_BLOCKS(IB), .OUTPUT_BLOCKS(OB), .CLK_DIV(2), .PROJECT_ID(PID)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]), .id_ok(idok[0]),
    .host_inputs(hin[0]), .host_outputs(hout[0]), .pmod_bus_clk(bclk[0]),
    .pmod_bus_control(ctrl[0]), .pmod_bus_poti(poti[0]), .pmod_bus_pito(pito[0]));

  ppb_host #(.INPUT_BLOCKS(IB), .OUTPUT_BLOCKS(OB), .CLK_DIV(1), .PROJECT_ID(PID)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]), .id_ok(idok[1]),
    .host_inputs(hin[1]), .host_outputs(hout[1]), .pmod_bus_clk(bclk[1]),
    .pmod_bus_control(ctrl[1]), .pmod_bus_poti(poti[1]), .pmod_bus_pito(pito[1]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return (HB + N) * 2 * div_of(i);
  endfunction

  function automatic logic [3*OB-1:0] rnd_blocks();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[3*OB-1:0];
  endfunction

  // Device side: answers each beat from its configured ID word and data blocks
  logic [23:0]     dev_id   [2];
  logic [3*OB-1:0] dev_data [2];
  int   d_beat   [2] = '{0, 0};
  logic d_busy_q [2] = '{1'b0, 1'b0};
  logic d_bclk_q [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] === 1'b1 && d_busy_q[i] !== 1'b1) d_beat[i] = 0;
      else if (busy[i] === 1'b1 && d_bclk_q[i] === 1'b1 && bclk[i] === 1'b0) d_beat[i] = d_beat[i] + 1;
      d_busy_q[i] = busy[i];
      d_bclk_q[i] = bclk[i];
      if (d_beat[i] < HB) pito[i] = dev_id[i][3*d_beat[i] +: 3];
      else if (d_beat[i] - HB < OB) pito[i] = dev_data[i][3*(d_beat[i]-HB) +: 3];
      else pito[i] = 3'($urandom);
    end
  end

  // Reference: m_c = cycle offset inside the accepted frame (0 = idle)
  int              m_c     [2] = '{0, 0};
  logic [3*IB-1:0] m_snap  [2];
  logic [23:0]     m_rid   [2];
  logic [3*OB-1:0] m_rdata [2];
  logic [3*OB-1:0] m_out   [2];
  logic            m_idok  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst !== 1'b1) begin
        m_c[i] = 0; m_idok[i] = 1'b0; m_out[i] = '0;
      end else if (m_c[i] == flen(i) + 1) begin
        m_idok[i] = (m_rid[i][22:0] == PID);
        if (m_idok[i]) m_out[i] = m_rdata[i];
        m_c[i] = 0;
      end else if (m_c[i] != 0) begin
        m_c[i] = m_c[i] + 1;
      end else if (start[i] === 1'b1) begin
        m_c[i] = 1; m_snap[i] = hin[i]; m_rid[i] = dev_id[i]; m_rdata[i] = dev_data[i];
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] idw_v;
    logic [7:0]  e;
    int c, b, ph, d;
    idw_v = IDW;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        c = m_c[i]; d = div_of(i);
        e = '0;
        e[5] = m_idok[i];
        if (c >= 1 && c <= flen(i)) begin
          b  = (c - 1) / (2 * d);
          ph = (c - 1) % (2 * d);
          e[7] = 1'b1;
          e[4] = (ph >= d);
          e[3] = (b < HB);
          if (b < HB) e[2:0] = idw_v[3*b +: 3];
          else if (b - HB < IB) e[2:0] = m_snap[i][3*(b-HB) +: 3];
        end else if (c == flen(i) + 1) begin
          e[6] = 1'b1;
        end
        chk($sformatf("dut%0d bus {busy,done,id_ok,clk,ctrl,poti}", i),
            {busy[i], done[i], idok[i], bclk[i], ctrl[i], poti[i]}, e);
        chk($sformatf("dut%0d host_outputs", i), hout[i], m_out[i]);
      end
    end
  end

  // Per-frame statistics of dut0 (CLK_DIV=2, so a beat is 4 cycles)
  int   s_len = 0, s_ctrl = 0, s_p7 = 0;
  logic s_prev = 1'b0;
  logic [2:0] s_hdr [8];
  always @(negedge clk) begin
    if (busy[0] === 1'b1) begin
      if (s_prev !== 1'b1) begin s_len = 0; s_ctrl = 0; s_p7 = 0; end
      if (ctrl[0] === 1'b1) begin
        if (s_len % 4 == 0 && s_len / 4 < 8) s_hdr[s_len/4] = poti[0];
        s_ctrl++;
      end else if (poti[0] === 3'b111) begin
        s_p7++;
      end
      s_len++;
    end
    s_prev = busy[0];
  end

  // dut1 runs with start held high: every completed frame must be 96 busy cycles
  int   r1_len = 0, r1_done = 0;
  logic r1_pd = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (done[1] === 1'b1) begin
        r1_done++;
        chk("dut1 frame busy cycles", r1_len, 96);
        chk("dut1 done width", r1_pd, 0);
        r1_len = 0;
      end else if (busy[1] === 1'b1) r1_len++;
      else r1_len = 0;
      r1_pd = done[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3*OB-1:0] pat, good;
    logic [2:0] hdr_lit [8];
    bit flip;
    hdr_lit = '{3'd0, 3'd1, 3'd5, 3'd3, 3'd4, 3'd3, 3'd4, 3'd1};
    for (int j = 0; j < OB; j++) pat[3*j +: 3] = 3'(j % 8);

    rst = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    hin[0] = '0; hin[1] = {$urandom, $urandom};
    dev_id[0] = IDW; dev_id[1] = IDW;
    dev_data[0] = pat; dev_data[1] = pat;
    tick(); chk_en = 1'b1;
    tick();
    chk("reset dut0 outputs", {busy[0], done[0], idok[0], bclk[0], ctrl[0], poti[0]}, 0);
    rst = 1'b1; start[1] = 1'b1;
    tick(); tick();

    // Loopback frame with the true ID
    hin[0] = {$urandom, $urandom};
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_done("frame A", 400); tick();
    chk("A busy cycles", s_len, 192);
    chk("A control cycles", s_ctrl, 32);
    for (int k = 0; k < 8; k++) chk($sformatf("A header beat %0d", k), s_hdr[k], hdr_lit[k]);
    chk("A id_ok", idok[0], 1);
    chk("A host_outputs", hout[0], pat);
    good = pat;

    // One ID bit flipped: outputs must hold
    dev_id[0] = IDW ^ (24'd1 << $urandom_range(0, 22));
    dev_data[0] = rnd_blocks();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_done("frame B", 400); tick();
    chk("B id_ok", idok[0], 0);
    chk("B host_outputs held", hout[0], good);

    // All-ones snapshot then inputs cleared right after start
    dev_id[0] = IDW;
    dev_data[0] = rnd_blocks();
    hin[0] = '1;
    start[0] = 1'b1; tick(); start[0] = 1'b0; hin[0] = '0;
    wait_done("frame C", 400); tick();
    chk("C poti 111 data cycles", s_p7, 80);
    chk("C id_ok", idok[0], 1);
    chk("C host_outputs", hout[0], dev_data[0]);
    good = dev_data[0];

    // Reset in data beat 4 (beat 12 overall), then a clean frame
    dev_data[0] = rnd_blocks();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (49) tick();
    rst = 1'b0; tick();
    chk("mid-frame reset dut0 outputs", {busy[0], done[0], idok[0], bclk[0], ctrl[0], poti[0]}, 0);
    chk("mid-frame reset dut0 host_outputs", hout[0], 0);
    chk("mid-frame reset dut1 outputs", {busy[1], done[1], idok[1], bclk[1], ctrl[1], poti[1], hout[1]}, 0);
    rst = 1'b1; tick();
    hin[0] = {$urandom, $urandom};
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_done("frame after reset", 400); tick();
    chk("post-reset id_ok", idok[0], 1);
    chk("post-reset host_outputs", hout[0], dev_data[0]);
    good = dev_data[0];

    // Randomized frames with dropped starts and inputs changing mid-frame
    for (int it = 0; it < 6; it++) begin
      flip = ($urandom_range(0, 2) == 0);
      dev_id[0] = flip ? (IDW ^ (24'd1 << $urandom_range(0, 22))) : IDW;
      dev_data[0] = rnd_blocks();
      hin[0] = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) tick();
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      repeat ($urandom_range(1, 150)) begin
        start[0] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) hin[0] = {$urandom, $urandom};
        tick();
      end
      start[0] = 1'b0;
      wait_done($sformatf("random frame %0d", it), 400);
      if (it == 2) start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      if (!flip) good = dev_data[0];
      chk($sformatf("R%0d busy after frame", it), busy[0], 0);
      chk($sformatf("R%0d id_ok", it), idok[0], !flip);
      chk($sformatf("R%0d host_outputs", it), hout[0], good);
    end

    repeat (4) tick();
    chk("dut1 completed frames >= 10", (r1_done >= 10), 1);
    chk("dut1 id_ok", idok[1], 1);
    chk("dut1 host_outputs", hout[1], pat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
